fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter limits for the FIFO write arbiter.
// Burst locking is enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned NREQ_MIN      = 2;
    localparam int unsigned NREQ_MAX      = 8;
    localparam int unsigned MAX_BURST_MIN = 1;
    localparam int unsigned MAX_BURST_MAX = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request at or after start, wrapping at NREQ-1.
// Purely combinational; handles non-power-of-2 NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(start) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NREQ write streams into one shared FIFO.
// Define FIFO_ARB_BURST_EN to lock a grant for up to MAX_BURST beats; otherwise one beat per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned BURST_LEN = MAX_BURST;
`else
    localparam int unsigned BURST_LEN = 1;
`endif

    generate
        if (NREQ < NREQ_MIN || NREQ > NREQ_MAX ||
            MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_param_err
            $error("fifo_wr_arbiter: NREQ or MAX_BURST out of range");
        end
    endgenerate

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   rr_ptr, pick_idx, sel_id, rel_ptr;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any, sel_valid, xfer, last_beat, release_c;
    logic [CW-1:0]   beat_cnt, cnt_after;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a grant that does not finish in its first beat becomes a locked burst
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any && !release_c) state_nxt = BURST;
            BURST:   if (release_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and transfer decision; back-pressure stalls without releasing the lock
    always_comb begin
        sel_id    = (state == IDLE) ? pick_idx : grant_id;
        sel_valid = (state == IDLE) ? pick_any : req_valid[grant_id];
        xfer      = rstn && !fifo_full && sel_valid;
        cnt_after = (state == IDLE) ? CW'(1) : beat_cnt + CW'(1);
        last_beat = xfer && (cnt_after == CW'(BURST_LEN));
        release_c = last_beat ||
                    (state == BURST && rstn && !fifo_full && !req_valid[grant_id]);
        rel_ptr   = (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + IW'(1);
        req_ready  = '0;
        fifo_wr_en = xfer;
        fifo_din   = '0;
        if (xfer) begin
            req_ready = (state == IDLE) ? pick_grant : (NREQ'(1) << grant_id);
            fifo_din  = req_data[32'(sel_id) * DWIDTH +: DWIDTH];
        end
    end

    assign busy = (state == BURST);

    // Grant, pointer and beat bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            if (state == IDLE && pick_any) grant_id <= pick_idx;
            if (release_c) begin
                rr_ptr   <= rel_ptr;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= cnt_after;
            end
        end
    end

endmodule
